axi4_lite_timer: RTL and testbench

- AXI4-Lite subordinate timer peripheral hung off one crossbar subordinate port, downstream of axi4_lite_crossbar.
- Prescaled 32-bit up-counter with compare match, auto-reload to 0, optional one-shot.
- Level interrupt drives the core's timer0_int/timer1_int inputs; SoC instantiates two copies.

---
 rtl/axi4_lite_timer_if.sv | 34 +++
 rtl/axi4_lite_timer.sv | 156 +++++++++++++++
 tb/tb_axi4_lite_timer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_timer_if.sv
// AXI4-Lite bus bundle shared by the crossbar and its subordinate peripherals.
// The subordinate modport is the view taken by a register block such as axi4_lite_timer.
interface axi4_lite #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH/8-1:0]    wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [WIDTH-1:0]      rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport subordinate (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport manager (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_timer.sv
// AXI4-Lite timer: prescaled up-counter with compare match, auto-reload to 0, one-shot and level irq.
// Define TIMER_PWM_EN to add the DUTY register at 0x10 and the registered pwm output.
module axi4_lite_timer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          irq,
`ifdef TIMER_PWM_EN
  output logic          pwm,
`endif
  axi4_lite.subordinate axi
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] IDX_CTRL    = IW'(0);
  localparam logic [IW-1:0] IDX_STATUS  = IW'(1);
  localparam logic [IW-1:0] IDX_COUNT   = IW'(2);
  localparam logic [IW-1:0] IDX_COMPARE = IW'(3);

  logic             en, oneshot, ie, match;
  logic [7:0]       prescale, pcnt;
  logic [WIDTH-1:0] count, compare, ctrl_word, ctrl_new, rd_value, rdata_q;
  logic             bvalid_q, rvalid_q;
  logic             wr_fire, ar_fire, tick, hit;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic             wr_ctrl, wr_status, wr_count, wr_compare, clr_match;
  logic             unused_bits;

`ifdef TIMER_PWM_EN
  localparam logic [IW-1:0] IDX_DUTY = IW'(4);
  logic [WIDTH-1:0] duty;
  logic             wr_duty;
`endif

  function automatic logic [WIDTH-1:0] merge_strb(input logic [WIDTH-1:0]   old_v,
                                                  input logic [WIDTH-1:0]   new_v,
                                                  input logic [WIDTH/8-1:0] strb);
    logic [WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < WIDTH/8; i++)
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    return res;
  endfunction

  // Address and data must arrive together; bvalid back-pressures the next write.
  assign wr_fire     = rst_n & axi.awvalid & axi.wvalid & ~bvalid_q;
  assign ar_fire     = rst_n & axi.arvalid & ~rvalid_q;
  assign axi.awready = wr_fire;
  assign axi.wready  = wr_fire;
  assign axi.arready = ar_fire;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = 2'b00;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = 2'b00;

  assign wr_idx     = axi.awaddr[ADDR_WIDTH-1:2];
  assign rd_idx     = axi.araddr[ADDR_WIDTH-1:2];
  assign wr_ctrl    = wr_fire && (wr_idx == IDX_CTRL);
  assign wr_status  = wr_fire && (wr_idx == IDX_STATUS);
  assign wr_count   = wr_fire && (wr_idx == IDX_COUNT);
  assign wr_compare = wr_fire && (wr_idx == IDX_COMPARE);
  assign clr_match  = wr_status & axi.wstrb[0] & axi.wdata[0];

  assign ctrl_word = {{(WIDTH-16){1'b0}}, prescale, 5'b0, ie, oneshot, en};
  assign ctrl_new  = merge_strb(ctrl_word, axi.wdata, axi.wstrb);

  assign tick = en && (pcnt == prescale);
  assign hit  = tick && (count == compare);
  assign irq  = match & ie;

  assign unused_bits = ^{axi.awaddr[1:0], axi.araddr[1:0], ctrl_new[WIDTH-1:16], ctrl_new[7:3]};

  always_comb begin
    rd_value = '0;
    case (rd_idx)
      IDX_CTRL:    rd_value = ctrl_word;
      IDX_STATUS:  rd_value = {{(WIDTH-1){1'b0}}, match};
      IDX_COUNT:   rd_value = count;
      IDX_COMPARE: rd_value = compare;
`ifdef TIMER_PWM_EN
      IDX_DUTY:    rd_value = duty;
`endif
      default:     rd_value = '0;
    endcase
  end

  // Software writes take priority over hardware updates, except a match set beats a W1C clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      oneshot  <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
      pcnt     <= '0;
      match    <= 1'b0;
      count    <= '0;
      compare  <= '1;
    end else begin
      if (wr_ctrl) begin
        en       <= ctrl_new[0];
        oneshot  <= ctrl_new[1];
        ie       <= ctrl_new[2];
        prescale <= ctrl_new[15:8];
      end else if (hit && oneshot) begin
        en <= 1'b0;
      end

      if (wr_ctrl || !en || tick) pcnt <= '0;
      else                        pcnt <= pcnt + 8'd1;

      if (wr_count)  count <= merge_strb(count, axi.wdata, axi.wstrb);
      else if (tick) count <= hit ? '0 : count + WIDTH'(1);

      if (hit)            match <= 1'b1;
      else if (clr_match) match <= 1'b0;

      if (wr_compare) compare <= merge_strb(compare, axi.wdata, axi.wstrb);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (wr_fire)         bvalid_q <= 1'b1;
      else if (axi.bready) bvalid_q <= 1'b0;

      if (ar_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_value;
      end else if (axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef TIMER_PWM_EN
  assign wr_duty = wr_fire && (wr_idx == IDX_DUTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      if (wr_duty) duty <= merge_strb(duty, axi.wdata, axi.wstrb);
      pwm <= en && (count < duty);
    end
  end
`endif

endmodule

// File: tb/tb_axi4_lite_timer.sv
// Self-checking bench for axi4_lite_timer: directed scenarios plus random AXI traffic against a model.
// Build with TIMER_PWM_EN defined to also cover the DUTY register and pwm output.
module tb_axi4_lite_timer;

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_STATUS = 5'h04;
  localparam logic [4:0] A_COUNT  = 5'h08;
  localparam logic [4:0] A_CMP    = 5'h0C;
  localparam logic [4:0] A_DUTY   = 5'h10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic irq;
`ifdef TIMER_PWM_EN
  logic pwm;
`endif

  axi4_lite #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

  axi4_lite_timer #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .irq  (irq),
`ifdef TIMER_PWM_EN
    .pwm  (pwm),
`endif
    .axi  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register file as the software sees it, advanced once per clock.
  logic        m_en, m_one, m_ie, m_match, m_bvalid, m_rvalid, m_pwm;
  int unsigned m_pre, m_phase;
  logic [31:0] m_count, m_cmp, m_duty, m_rdata;

  function automatic logic [31:0] mergeBytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ctrlWord();
    return {16'h0, 8'(m_pre), 5'h0, m_ie, m_one, m_en};
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] addr);
    case (addr[4:2])
      3'd0: return ctrlWord();
      3'd1: return {31'h0, m_match};
      3'd2: return m_count;
      3'd3: return m_cmp;
`ifdef TIMER_PWM_EN
      3'd4: return m_duty;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    m_en = 0; m_one = 0; m_ie = 0; m_match = 0; m_pre = 0; m_phase = 0;
    m_count = 0; m_cmp = 32'hFFFF_FFFF; m_duty = 0;
    m_bvalid = 0; m_rvalid = 0; m_rdata = 0; m_pwm = 0;
  endtask

  task automatic modelStep();
    logic        wfire, afire, tick, hit, n_en;
    logic [31:0] old_count, wv;
    wfire     = bus.awvalid && bus.wvalid && !m_bvalid;
    afire     = bus.arvalid && !m_rvalid;
    tick      = m_en && (m_phase == m_pre);
    hit       = tick && (m_count == m_cmp);
    old_count = m_count;
    if (afire) m_rdata = modelRead(bus.araddr);
    m_pwm   = m_en && (m_count < m_duty);
    m_phase = (m_en && !tick) ? m_phase + 1 : 0;
    n_en    = m_en;
    if (tick) begin
      if (hit) begin
        m_count = 0;
        m_match = 1;
        if (m_one) n_en = 0;
      end else begin
        m_count = m_count + 1;
      end
    end
    if (wfire) begin
      case (bus.awaddr[4:2])
        3'd0: begin
          wv = mergeBytes(ctrlWord(), bus.wdata, bus.wstrb);
          n_en = wv[0]; m_one = wv[1]; m_ie = wv[2]; m_pre = wv[15:8]; m_phase = 0;
        end
        3'd1: if (bus.wstrb[0] && bus.wdata[0] && !hit) m_match = 0;
        3'd2: m_count = mergeBytes(old_count, bus.wdata, bus.wstrb);
        3'd3: m_cmp = mergeBytes(m_cmp, bus.wdata, bus.wstrb);
`ifdef TIMER_PWM_EN
        3'd4: m_duty = mergeBytes(m_duty, bus.wdata, bus.wstrb);
`endif
        default: ;
      endcase
    end
    m_en     = n_en;
    m_bvalid = wfire || (m_bvalid && !bus.bready);
    m_rvalid = afire || (m_rvalid && !bus.rready);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else        modelStep();
  end

  // Compare every visible output against the model, half a cycle away from the active edge.
  always @(negedge clk) begin
    checkOutput("irq", irq, m_match & m_ie);
    checkOutput("awready", bus.awready, rst_n && bus.awvalid && bus.wvalid && !m_bvalid);
    checkOutput("wready", bus.wready, rst_n && bus.awvalid && bus.wvalid && !m_bvalid);
    checkOutput("arready", bus.arready, rst_n && bus.arvalid && !m_rvalid);
    checkOutput("bvalid", bus.bvalid, m_bvalid);
    checkOutput("rvalid", bus.rvalid, m_rvalid);
    if (m_bvalid) checkOutput("bresp", bus.bresp, 2'b00);
    if (m_rvalid) begin
      checkOutput("rdata", bus.rdata, m_rdata);
      checkOutput("rresp", bus.rresp, 2'b00);
    end
`ifdef TIMER_PWM_EN
    checkOutput("pwm", pwm, m_pwm);
`endif
  end

  task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay, input int b_stall, input bit offer);
    int cyc;
    bit fired;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb; bus.bready = (b_stall == 0);
    cyc = 0; fired = 0;
    while (!fired && cyc < 40) begin
      bus.awvalid = (cyc >= aw_delay);
      bus.wvalid  = (cyc >= w_delay);
      @(negedge clk);
      fired = bus.awready && bus.wready;
      @(posedge clk); #1;
      cyc++;
    end
    if (!fired) checkOutput("write_handshake_timeout", 32'd0, 32'd1);
    bus.awvalid = offer; bus.wvalid = offer;
    for (int s = 0; s < b_stall; s++) begin
      @(negedge clk);
      checkOutput("bvalid_held", bus.bvalid, 1'b1);
      if (offer) checkOutput("aw_blocked", bus.awready, 1'b0);
      @(posedge clk); #1;
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 1;
    cyc = 0; fired = 0;
    while (!fired && cyc < 40) begin
      @(negedge clk);
      fired = bus.bvalid;
      @(posedge clk); #1;
      cyc++;
    end
    if (!fired) checkOutput("bresp_timeout", 32'd0, 32'd1);
  endtask

  task automatic axiRead(input logic [4:0] addr, input int r_stall, output logic [31:0] data);
    int cyc;
    bit fired;
    data = 32'hDEAD_BEEF;
    bus.araddr = addr; bus.arvalid = 1; bus.rready = (r_stall == 0);
    cyc = 0; fired = 0;
    while (!fired && cyc < 40) begin
      @(negedge clk);
      fired = bus.arready;
      @(posedge clk); #1;
      cyc++;
    end
    if (!fired) checkOutput("ar_handshake_timeout", 32'd0, 32'd1);
    bus.arvalid = 0;
    repeat (r_stall) begin @(posedge clk); #1; end
    bus.rready = 1;
    cyc = 0; fired = 0;
    while (!fired && cyc < 40) begin
      @(negedge clk);
      if (bus.rvalid) begin fired = 1; data = bus.rdata; end
      @(posedge clk); #1;
      cyc++;
    end
    if (!fired) checkOutput("rvalid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    axiWrite(addr, data, 4'hF, 0, 0, 0, 0);
  endtask

  task automatic applyStimulus(input int n);
    logic [4:0]  a, ra;
    logic [31:0] d, rd;
    logic [3:0]  s;
    int          op;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 9);
      a  = 5'($urandom_range(0, 7) << 2) | 5'($urandom_range(0, 3));
      ra = 5'($urandom_range(0, 5) << 2) | 5'($urandom_range(0, 3));
      case (a[4:2])
        3'd0: begin d = $urandom; d[15:8] = 8'($urandom_range(0, 3)); end
        3'd2, 3'd3, 3'd4: d = $urandom_range(0, 12);
        default: d = $urandom;
      endcase
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if (op < 4) begin
        axiWrite(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 0);
      end else if (op < 8) begin
        axiRead(ra, $urandom_range(0, 3), rd);
      end else begin
        fork
          axiWrite(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 0);
          axiRead(ra, $urandom_range(0, 3), rd);
        join
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] rd, seq;
    bit          seen;
    int          highs;
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0; bus.bready = 1;
    bus.araddr = 0; bus.arvalid = 0; bus.rready = 1;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    $display("[TB] reset released");

    axiRead(A_CTRL, 0, rd);   checkOutput("reset_ctrl", rd, 32'h0);
    axiRead(A_STATUS, 0, rd); checkOutput("reset_status", rd, 32'h0);
    axiRead(A_COUNT, 0, rd);  checkOutput("reset_count", rd, 32'h0);
    axiRead(A_CMP, 0, rd);    checkOutput("reset_compare", rd, 32'hFFFF_FFFF);
    axiRead(A_DUTY, 0, rd);   checkOutput("reset_duty", rd, 32'h0);
    axiRead(5'h18, 0, rd);    checkOutput("unmapped_read", rd, 32'h0);
    wr(5'h1C, 32'hFFFF_FFFF);
    checkOutput("reset_irq", irq, 1'b0);

    $display("[TB] periodic match");
    wr(A_CMP, 32'd4);
    wr(A_CTRL, 32'h0000_0705);
    seq = 0; rd = 0;
    for (int k = 0; k < 60; k++) begin
      logic [31:0] prev;
      prev = rd;
      axiRead(A_COUNT, 0, rd);
      if (rd != prev) seq = (seq << 4) | (rd & 32'hF);
      if (rd == 0 && seq != 0) break;
    end
    checkOutput("count_sequence", seq, 32'h0001_2340);
    checkOutput("irq_after_wrap", irq, 1'b1);
    wr(A_CTRL, 32'h0000_0004);
    axiRead(A_STATUS, 0, rd); checkOutput("status_match", rd, 32'h1);
    wr(A_STATUS, 32'h1);
    @(negedge clk);
    checkOutput("irq_after_w1c", irq, 1'b0);
    axiRead(A_STATUS, 0, rd); checkOutput("status_cleared", rd, 32'h0);

    $display("[TB] one-shot");
    wr(A_COUNT, 32'h0);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h0000_0303);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      axiRead(A_STATUS, 0, rd);
      seen = rd[0];
    end
    checkOutput("oneshot_match_seen", seen, 1'b1);
    axiRead(A_CTRL, 0, rd);  checkOutput("oneshot_en_cleared", rd, 32'h0000_0302);
    axiRead(A_COUNT, 0, rd); checkOutput("oneshot_count_zero", rd, 32'h0);
    repeat (12) @(posedge clk);
    #1;
    axiRead(A_COUNT, 0, rd); checkOutput("oneshot_count_stays", rd, 32'h0);
    wr(A_STATUS, 32'h1);

    $display("[TB] strobes and write back-pressure");
    wr(A_CTRL, 32'h0);
    axiWrite(A_COUNT, 32'h1234_5678, 4'b0011, 0, 0, 5, 1);
    axiRead(A_COUNT, 0, rd); checkOutput("count_strobed", rd, 32'h0000_5678);

    $display("[TB] split aw/w during stalled read");
    fork
      axiRead(A_COUNT, 6, rd);
      axiWrite(A_CMP, 32'h55, 4'hF, 0, 3, 0, 0);
    join
    checkOutput("stalled_read_data", rd, 32'h0000_5678);
    axiRead(A_CMP, 0, rd); checkOutput("split_write_compare", rd, 32'h55);

    $display("[TB] reset during read");
    bus.araddr = A_COUNT; bus.arvalid = 1; bus.rready = 0;
    @(posedge clk); #1;
    bus.arvalid = 0;
    @(negedge clk);
    checkOutput("rvalid_before_reset", bus.rvalid, 1'b1);
    #2 rst_n = 0;
    #1;
    checkOutput("rvalid_async_reset", bus.rvalid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1; bus.rready = 1;
    axiRead(A_CMP, 0, rd);   checkOutput("compare_after_reset", rd, 32'hFFFF_FFFF);
    axiRead(A_COUNT, 0, rd); checkOutput("count_after_reset", rd, 32'h0);

    $display("[TB] duty register");
    wr(A_DUTY, 32'd3);
    axiRead(A_DUTY, 0, rd);
`ifdef TIMER_PWM_EN
    checkOutput("duty_readback", rd, 32'd3);
    wr(A_CMP, 32'd9);
    wr(A_CTRL, 32'h1);
    repeat (15) @(posedge clk);
    highs = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pwm) highs++;
    end
    checkOutput("pwm_high_per_40", highs, 32'd12);
    @(posedge clk); #1;
    wr(A_CTRL, 32'h0);
`else
    checkOutput("duty_absent", rd, 32'h0);
    highs = 0;
`endif

    $display("[TB] random traffic");
    wr(A_STATUS, 32'h1);
    applyStimulus(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
